// File: rtl/psum_acc_seq.sv
// Partial-sum accumulator: pops OFIFO rows, maps each input row nij to an output pixel
// onij for the current kernel offset kij, and read-modify-writes the PSUM SRAM.
module psum_acc_seq #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int len_nij = 36,
    parameter int addr_w  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               kij,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_dout,
    output logic                     ofifo_rd,
    output logic                     pmem_cen,
    output logic                     pmem_wen,
    output logic [addr_w-1:0]        pmem_a,
    output logic [col*psum_bw-1:0]   pmem_d,
    input  logic [col*psum_bw-1:0]   pmem_q,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int row_w  = col * psum_bw;
    localparam int nij_w  = $clog2(len_nij);
    localparam int in_dim = 6;
    localparam int k_dim  = 3;

    typedef enum logic [2:0] {IDLE, WAIT, CAPT, RD, WR} state_t;

    state_t              state, next_state;
    logic [nij_w-1:0]    nij;
    logic [3:0]          kij_r;
    logic                relu_r;
    logic [row_w-1:0]    row_r;

    logic [2:0]          nx, ny;
    logic [1:0]          kx, ky;
    logic signed [3:0]   ox, oy;
    logic                row_valid;
    logic                last_row;
    logic [addr_w-1:0]   onij;

    logic                accept, reject;
    logic                nij_inc, retire_last;
    logic [row_w-1:0]    result;
    logic [psum_bw-1:0]  lane_acc, lane_sum;

    assign accept = (state == IDLE) && start && (kij <= 4'd8);
    assign reject = (state == IDLE) && start && (kij > 4'd8);
    assign busy   = (state != IDLE);

    // Output-pixel coordinates; a row maps to a valid pixel only when both offsets land in 0..3.
    assign nx        = 3'(nij % in_dim);
    assign ny        = 3'(nij / in_dim);
    assign kx        = 2'(kij_r % k_dim);
    assign ky        = 2'(kij_r / k_dim);
    assign ox        = $signed({1'b0, nx}) - $signed({2'b00, kx});
    assign oy        = $signed({1'b0, ny}) - $signed({2'b00, ky});
    assign row_valid = !ox[3] && !ox[2] && !oy[3] && !oy[2];
    assign onij      = addr_w'({oy[1:0], ox[1:0]});
    assign last_row  = (nij == nij_w'(len_nij - 1));

    always_comb begin
        result   = '0;
        lane_acc = '0;
        lane_sum = '0;
        for (int c = 0; c < col; c++) begin
            lane_acc = (kij_r == 4'd0) ? '0 : pmem_q[c*psum_bw +: psum_bw];
            lane_sum = lane_acc + row_r[c*psum_bw +: psum_bw];
            if (relu_r && (kij_r == 4'd8) && lane_sum[psum_bw-1])
                lane_sum = '0;
            result[c*psum_bw +: psum_bw] = lane_sum;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        next_state  = state;
        ofifo_rd    = 1'b0;
        pmem_cen    = 1'b1;
        pmem_wen    = 1'b1;
        pmem_a      = '0;
        pmem_d      = '0;
        nij_inc     = 1'b0;
        retire_last = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    next_state = WAIT;
            end
            WAIT: begin
                if (ofifo_valid) begin
                    ofifo_rd   = 1'b1;
                    next_state = CAPT;
                end
            end
            CAPT: begin
                if (!row_valid) begin
                    nij_inc     = 1'b1;
                    retire_last = last_row;
                    next_state  = last_row ? IDLE : WAIT;
                end else if (kij_r == 4'd0) begin
                    next_state = WR;
                end else begin
                    next_state = RD;
                end
            end
            RD: begin
                pmem_cen   = 1'b0;
                pmem_a     = onij;
                next_state = WR;
            end
            WR: begin
                pmem_cen    = 1'b0;
                pmem_wen    = 1'b0;
                pmem_a      = onij;
                pmem_d      = result;
                nij_inc     = 1'b1;
                retire_last = last_row;
                next_state  = last_row ? IDLE : WAIT;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            nij    <= '0;
            kij_r  <= '0;
            relu_r <= 1'b0;
            row_r  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= next_state;
            done  <= retire_last;
            err   <= reject;
            if (accept) begin
                kij_r  <= kij;
                relu_r <= relu_en;
                nij    <= '0;
            end else if (nij_inc) begin
                nij <= nij + 1'b1;
            end
            if (state == CAPT)
                row_r <= ofifo_dout;
        end
    end

endmodule

// File: tb/tb_psum_acc_seq.sv
// Directed bench for psum_acc_seq: models the OFIFO and PSUM SRAM, runs kij passes and
// compares stored results against hand-computed values.
module tb_psum_acc_seq;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int W   = COL * BW;
    localparam int AW  = 11;
    localparam int NIJ = 36;

    logic          clk = 1'b0;
    logic          reset, start, relu_en, ofifo_valid;
    logic [3:0]    kij;
    logic [W-1:0]  ofifo_dout, pmem_q, pmem_d;
    logic          ofifo_rd, pmem_cen, pmem_wen, busy, done, err;
    logic [AW-1:0] pmem_a;

    always #5 clk = ~clk;

    psum_acc_seq #(.col(COL), .psum_bw(BW), .len_nij(NIJ), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .kij(kij), .relu_en(relu_en),
        .ofifo_valid(ofifo_valid), .ofifo_dout(ofifo_dout), .ofifo_rd(ofifo_rd),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a), .pmem_d(pmem_d),
        .pmem_q(pmem_q), .busy(busy), .done(done), .err(err)
    );

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [BW-1:0] row_val [0:NIJ-1];
    logic [BW-1:0] lane_step;
    int            wr_cnt [0:15];
    int            n_checks, n_fail;
    int            pop_cnt, wr_total, order_viol, rd_no_valid, err_cnt, done_cnt;
    int            busy_cycles, first_wr_pop, oob_wr, cyc;
    logic          pend_pop, pend_rd, pend_wr;
    logic [AW-1:0] pend_rd_a, pend_wr_a;
    logic [W-1:0]  pend_wr_d;
    logic [3:0]    pass_kij;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] row_word(input int n);
        logic [W-1:0] r;
        r = '0;
        if (n < NIJ)
            for (int c = 0; c < COL; c++) r[c*BW +: BW] = row_val[n] + BW'(c) * lane_step;
        return r;
    endfunction

    // One clock cycle: commit last cycle's SRAM/FIFO effects, drive inputs, then observe outputs.
    task automatic step(input logic v);
        logic          prev_rd;
        logic [AW-1:0] prev_a;
        @(negedge clk);
        if (pend_pop) begin
            ofifo_dout = row_word(pop_cnt);
            pop_cnt++;
        end
        if (pend_wr) mem[pend_wr_a] = pend_wr_d;
        if (pend_rd) pmem_q = mem[pend_rd_a];
        ofifo_valid = v;
        #1;
        prev_rd   = pend_rd;
        prev_a    = pend_rd_a;
        pend_pop  = ofifo_rd;
        pend_rd   = !pmem_cen && pmem_wen;
        pend_rd_a = pmem_a;
        pend_wr   = !pmem_cen && !pmem_wen;
        pend_wr_a = pmem_a;
        pend_wr_d = pmem_d;
        if (ofifo_rd && !ofifo_valid) rd_no_valid++;
        if (pend_wr) begin
            wr_total++;
            if (wr_total == 1) first_wr_pop = pop_cnt;
            if (pmem_a < AW'(16)) wr_cnt[pmem_a[3:0]]++;
            else oob_wr++;
            if (pass_kij != 4'd0 && !(prev_rd && prev_a == pmem_a)) order_viol++;
        end
        if (done) done_cnt++;
        if (busy) busy_cycles++;
        if (err)  err_cnt++;
        cyc++;
    endtask

    task automatic clear_stats();
        pop_cnt = 0; wr_total = 0; order_viol = 0; rd_no_valid = 0; err_cnt = 0;
        done_cnt = 0; busy_cycles = 0; first_wr_pop = -1; oob_wr = 0;
        for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
    endtask

    task automatic preload(input logic [BW-1:0] v);
        for (int i = 0; i < 16; i++) mem[i] = rep(v);
    endtask

    task automatic set_rows(input int mode, input logic [BW-1:0] v);
        for (int n = 0; n < NIJ; n++) row_val[n] = (mode == 0) ? BW'(n) : v;
    endtask

    function automatic int once_cnt();
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) if (wr_cnt[i] == 1) k++;
        return k;
    endfunction

    // mode 0: ofifo_valid always high; mode 1: high one cycle in three.
    task automatic run_pass(input logic [3:0] k, input logic relu, input int mode, input int bad_start_at);
        clear_stats();
        pass_kij = k;
        start = 1'b1; kij = k; relu_en = relu;
        step((mode == 0) || (cyc % 3 == 0));
        start = 1'b0;
        check("busy_after_start", W'(busy), W'(1'b1));
        for (int i = 0; i < 1000 && done_cnt == 0; i++) begin
            if (i == bad_start_at) begin start = 1'b1; kij = 4'd9; end
            step((mode == 0) || (cyc % 3 == 0));
            start = 1'b0;
        end
        check("pass_done_seen", W'(done_cnt > 0), W'(1'b1));
        step(1'b0);
        check("done_one_cycle", W'(done_cnt), W'(1));
        check("pops_per_pass", W'(pop_cnt), W'(NIJ));
        check("writes_per_pass", W'(wr_total), W'(16));
        check("addrs_written_once", W'(once_cnt()), W'(16));
        check("no_out_of_range_wr", W'(oob_wr), W'(0));
    endtask

    logic [W-1:0] exp_row;
    logic         found;
    int           wr_snap;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; kij = '0; relu_en = 1'b0; ofifo_valid = 1'b0;
        ofifo_dout = '0; pmem_q = '0; lane_step = '0; pass_kij = '0;
        pend_pop = 1'b0; pend_rd = 1'b0; pend_wr = 1'b0;
        pend_rd_a = '0; pend_wr_a = '0; pend_wr_d = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        clear_stats();

        // Reset state
        step(1'b0);
        step(1'b1);
        check("rst_ofifo_rd", W'(ofifo_rd), W'(1'b0));
        check("rst_pmem_cen", W'(pmem_cen), W'(1'b1));
        check("rst_pmem_wen", W'(pmem_wen), W'(1'b1));
        check("rst_pmem_a",   W'(pmem_a),   W'(0));
        check("rst_pmem_d",   pmem_d,       W'(0));
        check("rst_busy",     W'(busy),     W'(1'b0));
        check("rst_done",     W'(done),     W'(1'b0));
        check("rst_err",      W'(err),      W'(1'b0));
        reset = 1'b0;

        // kij=0 pass: row n carries n; address o gets row nij = (o/4)*6 + o%4
        set_rows(0, '0);
        run_pass(4'd0, 1'b0, 0, -1);
        check("k0_busy_cycles", W'(busy_cycles), W'(88));
        check("k0_first_wr_pop", W'(first_wr_pop), W'(1));
        check("k0_addr0",  mem[0],  rep(16'd0));
        check("k0_addr5",  mem[5],  rep(16'd7));
        check("k0_addr15", mem[15], rep(16'd21));

        // kij=4 pass adds 1 everywhere; nij 0..6 discarded
        set_rows(1, 16'd1);
        run_pass(4'd4, 1'b0, 0, -1);
        check("k4_busy_cycles", W'(busy_cycles), W'(104));
        check("k4_first_wr_pop", W'(first_wr_pop), W'(8));
        check("k4_read_before_write", W'(order_viol), W'(0));
        check("k4_addr0",  mem[0],  rep(16'd1));
        check("k4_addr5",  mem[5],  rep(16'd8));
        check("k4_addr15", mem[15], rep(16'd22));

        // ReLU on kij=8: 5 + (-9) = -4 -> 0 with relu, 0xFFFC without
        set_rows(1, 16'hFFF7);
        preload(16'd5);
        run_pass(4'd8, 1'b1, 0, -1);
        check("k8_relu_first_wr_pop", W'(first_wr_pop), W'(15));
        check("k8_relu_addr0",  mem[0],  rep(16'h0000));
        check("k8_relu_addr15", mem[15], rep(16'h0000));
        preload(16'd5);
        run_pass(4'd8, 1'b0, 0, -1);
        check("k8_norelu_addr0",  mem[0],  rep(16'hFFFC));
        check("k8_norelu_addr10", mem[10], rep(16'hFFFC));
        preload(16'd5);
        run_pass(4'd2, 1'b1, 0, -1);
        check("k2_relu_ignored_addr3", mem[3], rep(16'hFFFC));

        // Wrap: 0x7FFF + (1 + lane) -> 0x8000 + lane
        set_rows(1, 16'd1);
        lane_step = 16'd1;
        preload(16'h7FFF);
        run_pass(4'd1, 1'b0, 0, -1);
        for (int c = 0; c < COL; c++) exp_row[c*BW +: BW] = 16'h8000 + BW'(c);
        check("wrap_addr0",  mem[0],  exp_row);
        check("wrap_addr15", mem[15], exp_row);
        lane_step = '0;

        // Sparse ofifo_valid, plus a stray start mid-pass that must be ignored
        set_rows(0, '0);
        preload(16'd0);
        run_pass(4'd0, 1'b0, 1, 10);
        check("sparse_rd_only_when_valid", W'(rd_no_valid), W'(0));
        check("sparse_start_ignored", W'(err_cnt), W'(0));
        check("sparse_addr0",  mem[0],  rep(16'd0));
        check("sparse_addr5",  mem[5],  rep(16'd7));
        check("sparse_addr15", mem[15], rep(16'd21));

        // Rejected start
        start = 1'b1; kij = 4'd9;
        step(1'b0);
        start = 1'b0;
        check("bad_kij_err", W'(err), W'(1'b1));
        check("bad_kij_busy", W'(busy), W'(1'b0));
        step(1'b0);
        check("bad_kij_err_pulse", W'(err), W'(1'b0));
        check("bad_kij_still_idle", W'(busy), W'(1'b0));

        // Reset during RD abandons the pass with no write
        clear_stats();
        pass_kij = 4'd1;
        set_rows(1, 16'd1);
        preload(16'd0);
        start = 1'b1; kij = 4'd1; relu_en = 1'b0;
        step(1'b1);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!pmem_cen && pmem_wen) found = 1'b1;
            else step(1'b1);
        end
        check("rd_reached", W'(found), W'(1'b1));
        wr_snap = wr_total;
        reset = 1'b1;
        #1;
        check("rst_in_rd_cen", W'(pmem_cen), W'(1'b1));
        check("rst_in_rd_busy", W'(busy), W'(1'b0));
        step(1'b1);
        step(1'b1);
        check("rst_in_rd_no_write", W'(wr_total), W'(wr_snap));
        check("rst_in_rd_mem_kept", mem[0], rep(16'd0));
        reset = 1'b0;

        // Start right after reset release is accepted on the first edge
        set_rows(0, '0);
        run_pass(4'd0, 1'b0, 0, -1);
        check("post_rst_addr5", mem[5], rep(16'd7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
